cpu_core: RTL

Parametrised multi-cycle CPU core, the successor to the fixed 8-bit three-phase CPU.
- Runs on a single clock with no derived clocks.
- Talks to memory over a req/ack handshake, so any memory latency works.
- Provides NUM_REGS general registers, zero and carry flags, and a registered output port in place of simulation-only prints.
- Sits between the top-level memory and the output/display logic.

---
 rtl/cpu_core_pkg.sv | 28 ++
 rtl/cpu_regfile.sv | 29 ++
 rtl/cpu_core.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: opcodes, instruction field positions and FSM state encodings shared by the core
package cpu_core_pkg;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LD  = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_MOV = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JEZ = 4'h7;
    localparam logic [3:0] OP_JNZ = 4'h8;
    localparam logic [3:0] OP_JC  = 4'h9;
    localparam logic [3:0] OP_OUT = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam int OP_HI = 7;
    localparam int OP_LO = 4;
    localparam int RD_HI = 3;
    localparam int RD_LO = 2;
    localparam int RS_HI = 1;
    localparam int RS_LO = 0;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ARG, S_MEM, S_HALT} state_t;
    function automatic logic is_jump(input logic [3:0] op);
        return op inside {OP_JMP, OP_JEZ, OP_JNZ, OP_JC};
    endfunction
    function automatic logic has_arg(input logic [3:0] op);
        return is_jump(op) || op inside {OP_LD, OP_ST};
    endfunction
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: NUM_REGS x DATA_W registers, two combinational read ports, one write port, async clear
module cpu_regfile #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int IW       = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IW-1:0]     rd_sel,
    input  logic [IW-1:0]     rs_sel,
    output logic [DATA_W-1:0] rd_val,
    output logic [DATA_W-1:0] rs_val,
    input  logic              we,
    input  logic [IW-1:0]     wsel,
    input  logic [DATA_W-1:0] wdata
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    always_comb begin
        regs_d = regs_q;
        if (we) regs_d[wsel] = wdata;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end
    assign rd_val = regs_q[rd_sel];
    assign rs_val = regs_q[rs_sel];
endmodule

// File: rtl/cpu_core.sv
// cpu_core: parametrised multi-cycle CPU with req/ack memory port, flags, output port and halt
module cpu_core
    import cpu_core_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                NUM_REGS = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              halted
);
    localparam int IW = $clog2(NUM_REGS);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d;
    logic [7:0]        ir_q, ir_d;
    logic              z_q, z_d, c_q, c_d, out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d, rd_val, rs_val, rf_wdata;
    logic [DATA_W:0]   res;
    logic              rf_we, taken;
    logic [3:0]        op;
    logic [IW-1:0]     rd_sel, rs_sel;
    assign op     = ir_q[OP_HI:OP_LO];
    assign rd_sel = IW'(ir_q[RD_HI:RD_LO] % NUM_REGS);
    assign rs_sel = IW'(ir_q[RS_HI:RS_LO] % NUM_REGS);
    assign res    = op == OP_ADD ? {1'b0, rd_val} + {1'b0, rs_val} : {1'b0, rd_val} - {1'b0, rs_val};
    assign taken  = op == OP_JMP || (op == OP_JEZ && z_q) || (op == OP_JNZ && !z_q) || (op == OP_JC && c_q);
    cpu_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IW(IW)) u_regfile (
        .clk    (clk),
        .reset  (reset),
        .rd_sel (rd_sel),
        .rs_sel (rs_sel),
        .rd_val (rd_val),
        .rs_val (rs_val),
        .we     (rf_we),
        .wsel   (rd_sel),
        .wdata  (rf_wdata)
    );
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        addr_d      = addr_q;
        z_d         = z_q;
        c_d         = c_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        rf_we       = 1'b0;
        rf_wdata    = state_q == S_MEM ? mem_rdata : op == OP_MOV ? rs_val : res[DATA_W-1:0];
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: if (mem_ack) begin
                ir_d    = mem_rdata[7:0];
                pc_d    = pc_q + 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = op == OP_HLT ? S_HALT : has_arg(op) ? S_ARG : S_FETCH;
                rf_we   = op inside {OP_ADD, OP_SUB, OP_MOV};
                if (op inside {OP_ADD, OP_SUB}) begin
                    c_d = res[DATA_W];
                    z_d = res[DATA_W-1:0] == '0;
                end
                if (op == OP_OUT) begin
                    out_valid_d = 1'b1;
                    out_data_d  = rd_val;
                end
            end
            S_ARG: if (mem_ack) begin
                addr_d  = mem_rdata[ADDR_W-1:0];
                pc_d    = is_jump(op) && taken ? mem_rdata[ADDR_W-1:0] : pc_q + 1'b1;
                state_d = is_jump(op) ? S_FETCH : S_MEM;
            end
            S_MEM: if (mem_ack) begin
                rf_we   = op == OP_LD;
                state_d = S_FETCH;
            end
            default: state_d = state_q;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            addr_q      <= '0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            addr_q      <= addr_d;
            z_q         <= z_d;
            c_q         <= c_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
    assign mem_req   = state_q inside {S_FETCH, S_ARG, S_MEM};
    assign mem_we    = state_q == S_MEM && op == OP_ST;
    assign mem_addr  = state_q == S_MEM ? addr_q : pc_q;
    assign mem_wdata = rd_val;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign halted    = state_q == S_HALT;
endmodule
